// File: rtl/mul_div_unit.sv
// mul_div_unit: execute-stage HI/LO unit for mult/multu/div/divu/mthi/mtlo.
// The result is computed combinationally from latched operand copies and committed
// to HI/LO after a fixed busy period timed by a down-counter.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   start    EX-stage mulDiv-class instruction valid this cycle
//   op       000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
//   cancel   EX instruction is being flushed; suppresses a same-cycle start
//   a, b     rs / rt operands
//   busy     computation in progress
//   occupied busy, or a compute op being accepted this cycle (for the hazard unit)
//   hi, lo   HI/LO registers
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        occupied,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   counter_q, counter_d;
    logic [1:0]        op_q;
    logic [31:0]       a_q, b_q;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic              accept;

    // Datapath signals, all derived from the latched operands.
    logic [63:0]       prod_s, prod_u;
    logic              a_neg, b_neg;
    logic [31:0]       mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

    assign accept   = start & ~cancel & (state_q == StIdle);
    assign busy     = (state_q == StBusy);
    assign occupied = busy | (start & ~cancel & ~op[2]);
    assign hi       = hi_q;
    assign lo       = lo_q;

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division via magnitudes: avoids the 0x80000000 / -1 overflow corner,
    // which falls out naturally as quotient 0x80000000, remainder 0.
    assign a_neg   = ~op_q[0] & a_q[31];
    assign b_neg   = ~op_q[0] & b_q[31];
    assign mag_a   = a_neg ? (32'd0 - a_q) : a_q;
    assign mag_b   = b_neg ? (32'd0 - b_q) : b_q;
    // Divide-by-zero result is discarded; the guard just keeps the divider defined.
    assign divisor = (b_q == 32'd0) ? 32'd1 : mag_b;
    assign q_mag   = mag_a / divisor;
    assign r_mag   = mag_a % divisor;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op)
                        3'b000, 3'b001: begin
                            state_d   = StBusy;
                            counter_d = CntW'(MULT_CYCLES);
                        end
                        3'b010, 3'b011: begin
                            state_d   = StBusy;
                            counter_d = CntW'(DIV_CYCLES);
                        end
                        3'b100:  hi_d = a;
                        3'b101:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                counter_d = counter_q - 1'b1;
                if (counter_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (!op_q[1]) begin
                        hi_d = op_q[0] ? prod_u[63:32] : prod_s[63:32];
                        lo_d = op_q[0] ? prod_u[31:0]  : prod_s[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            counter_q <= '0;
            op_q      <= 2'b00;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            if (accept) begin
                op_q <= op[1:0];
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases from the test plan plus
// random operations checked against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] a, b;
    logic        busy, occupied;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int illegal_starts = 0;

    logic [31:0] m_hi, m_lo;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .cancel   (cancel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .occupied (occupied),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Counts starts presented while a computation is in flight.
    always @(posedge clk) begin
        if (start && busy && !reset) illegal_starts <= illegal_starts + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the instruction semantics.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, up;
        logic [63:0]     v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        case (o)
            3'b000: begin v = 64'(sx * sy); m_hi = v[63:32]; m_lo = v[31:0]; end
            3'b001: begin up = ux * uy; v = up; m_hi = v[63:32]; m_lo = v[31:0]; end
            3'b010: if (y != 0) begin
                sq = sx / sy; sr = sx % sy;
                v = 64'(sq); m_lo = v[31:0];
                v = 64'(sr); m_hi = v[31:0];
            end
            3'b011: if (y != 0) begin
                v = ux / uy; m_lo = v[31:0];
                v = ux % uy; m_hi = v[31:0];
            end
            3'b100: m_hi = x;
            3'b101: m_lo = x;
            default: ;
        endcase
    endtask

    // Presents one start for one cycle; returns at the negedge of cycle T+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic c);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cancel = c;
        #1;
        check("occupied_at_start", 32'(occupied), 32'(busy | (!c && o < 3'd4)));
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        a = $urandom; b = $urandom;  // result must come from the latched copies
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic cancel_in_busy);
        int n;
        n = (o <= 3'd1) ? 5 : (o <= 3'd3) ? 10 : 0;
        issue(o, x, y, 1'b0);
        for (int i = 0; i < n; i++) begin
            cancel = cancel_in_busy;
            check($sformatf("busy_op%0d_cyc%0d", o, i + 1), 32'(busy), 32'd1);
            @(negedge clk);
        end
        cancel = 1'b0;
        model(o, x, y);
        check($sformatf("busy_done_op%0d", o), 32'(busy), 32'd0);
        check($sformatf("hi_op%0d_%h_%h", o, x, y), hi, m_hi);
        check($sformatf("lo_op%0d_%h_%h", o, x, y), lo, m_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 3'b000; cancel = 1'b0; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // Directed arithmetic cases with literal expectations.
        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg2x3_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg2x3_lo", lo, 32'hFFFF_FFFA);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'h0000_0001);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // mthi/mtlo, then divide by zero leaves them intact.
        run_op(3'b100, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0);
        run_op(3'b101, 32'h0000_5678, 32'hDEAD_BEEF, 1'b0);
        run_op(3'b010, 32'h0000_0100, 32'd0, 1'b0);
        check("div0_hi", hi, 32'h0000_1234);
        check("div0_lo", lo, 32'h0000_5678);
        run_op(3'b110, 32'hAAAA_AAAA, 32'd1, 1'b0);
        check("noop_hi", hi, 32'h0000_1234);

        // Cancelled start: nothing happens.
        issue(3'b000, 32'd3, 32'd4, 1'b1);
        check("cancel_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check("cancel_busy_late", 32'(busy), 32'd0);
        check("cancel_hi", hi, m_hi);
        check("cancel_lo", lo, m_lo);

        // Cancel during BUSY does not affect the computation.
        run_op(3'b000, 32'd3, 32'd4, 1'b1);
        check("cancel_in_busy_lo", lo, 32'd12);

        // Reset in cycle 3 of BUSY aborts with no later writeback.
        issue(3'b000, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check("midreset_late_busy", 32'(busy), 32'd0);
        check("midreset_late_hi", hi, 32'd0);
        check("midreset_late_lo", lo, 32'd0);

        // Illegal start while busy: must be ignored.
        issue(3'b001, 32'd1000, 32'd77, 1'b0);
        check("ill_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        check("ill_busy2", 32'(busy), 32'd1);
        start = 1'b1; op = 3'b010; a = 32'd99; b = 32'd5;
        #1;
        check("ill_occupied", 32'(occupied), 32'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            check($sformatf("ill_busy%0d", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        model(3'b001, 32'd1000, 32'd77);
        check("ill_done_busy", 32'(busy), 32'd0);
        check("ill_hi", hi, m_hi);
        check("ill_lo", lo, 32'd77000);
        check("illegal_start_seen", 32'(illegal_starts), 32'd1);

        // Random operations against the model.
        for (int k = 0; k < 24; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
